seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
Parametrised serial pattern detector, the next generation of the fixed three-ones Mealy detector. It samples one bit per clock on `x` and flags a programmable PAT_LEN-bit pattern with two outputs: a same-cycle Mealy output and a registered Moore-style output. Overlapping or non-overlapping matching is selected at run time. It sits on serial-bit datapaths as a frame-sync or marker detector.

Parameters:
- PAT_LEN, 3: pattern length in bits. Legal range 2..32.
- PATTERN, 3'b111: pattern to detect. MSB is the oldest bit received; LSB is the bit presented in the match cycle.
- CNT_W, 8: width of the match counter (see Optional Feature).

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- en, input, 1: sample enable. `x` is consumed only when en=1.
- x, input, 1: serial data bit.
- overlap, input, 1: 1 = overlapping match, 0 = non-overlapping. Sampled every enabled cycle.
- y, output, 1: Mealy match. Combinational from state and x.
- y_q, output, 1: registered match. Equals y delayed by one clock.
- match_cnt, output, CNT_W: number of matches since reset.

Behaviour:
- State:
  - hist[PAT_LEN-2:0]: the last PAT_LEN-1 accepted bits, newest in the LSB.
  - fill: 0..PAT_LEN-1, the number of valid bits in hist since reset or since the last non-overlap match.
- Reset (rst=1 at a rising edge): hist=0, fill=0, y_q=0, match_cnt=0. y=0 during and after reset until fill reaches PAT_LEN-1. rst has priority over en.
- y = en & (fill==PAT_LEN-1) & ({hist,x}==PATTERN). It is purely combinational, so latency is zero cycles from the final pattern bit on x.
- On a rising edge with en=1 and no reset:
  - hist <= {hist[PAT_LEN-3:0], x}. For PAT_LEN=2, hist <= x.
  - If y=1 and overlap=0: fill <= 0, so the next match needs PAT_LEN fresh bits.
  - Otherwise: fill <= min(fill+1, PAT_LEN-1). fill saturates and never wraps.
- With en=0: hist and fill hold, y=0, and y_q <= 0 on that edge.
- y_q <= y on every non-reset edge, so y_q is a one-cycle pulse per match.
- Overlap mode, default pattern, input stream 1,1,1,1,1: y=1 on bits 3, 4 and 5.
- Non-overlap mode, same stream: y=1 on bit 3 only. The next match is possible at bit 6.
- overlap changing mid-stream takes effect on the next match only. fill is unaffected until a match occurs.
- Back-to-back matches: y may be high on consecutive enabled cycles in overlap mode. y_q then stays high continuously.
- Reset asserted mid-pattern discards the partial match. No y follows for bits received before the reset.
- Idle cycles (en=0) inside a pattern do not break it. The pattern is matched over enabled bits only.

Optional Feature:
- Macro: SEQ_DETECT_MATCH_CNT_EN.
- Defined:
  - match_cnt increments by 1 on every edge where y=1 and rst=0.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - rst clears it to 0.
- Not defined:
  - No counter register is built; match_cnt is tied to constant 0.
  - All other behaviour is identical.

Test Plan:
- Default parameters, overlap=1, en=1, reset 2 cycles, then x=1 for 5 clocks, then x=0 for 3 clocks -> y high on clocks 3, 4, 5 of the ones; y_q high on clocks 4, 5, 6; match_cnt=3 (macro on) or 0 (macro off).
- Same stimulus with overlap=0 -> y high on clock 3 only; y_q high on clock 4; match_cnt=1.
- PAT_LEN=4, PATTERN=4'b1011, overlap=1, stream 1,0,1,1,0,1,1 -> y on bits 4 and 7. With overlap=0 -> y on bit 4 only; bits 5–7 only refill fill, so bit 7 does not match.
- Default parameters, x=1,1 then en=0 for 3 cycles with x=1, then en=1 with x=1 -> single y on the re-enable cycle; y=0 throughout the en=0 cycles.
- Default parameters, x=1,1, then rst=1 for 1 clock while x=1, then x=1,1 -> no y; y first asserts on the 3rd bit after reset.
- Macro on, CNT_W=2, overlap=1, x=1 for 10 clocks -> match_cnt reaches 3 and holds at 3 while y continues pulsing.

Source files
------------

// File: rtl/seq_detect_param_if.sv
// Serial-bit interface for seq_detect_param: sample enable, data, overlap mode in; match flags and count out.
interface seq_detect_param_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             x;
  logic             overlap;
  logic             y;
  logic             y_q;
  logic [CNT_W-1:0] match_cnt;

  // No handshake: one bit is accepted on every rising edge where en=1; there is no back-pressure.
  modport master (output en, output x, output overlap, input y, input y_q, input match_cnt);
  modport slave  (input en, input x, input overlap, output y, output y_q, output match_cnt);
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with Mealy (y) and registered (y_q) match outputs.
// Optional saturating match counter is built only when SEQ_DETECT_MATCH_CNT_EN is defined.
module seq_detect_param #(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b111,
  parameter int                 CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  seq_detect_param_if.slave   bus
);

  localparam int                FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               match_q, match_d;
  logic               y;

  if (PAT_LEN == 2) begin : g_hist_one
    assign hist_shift = bus.x;
  end else begin : g_hist_many
    assign hist_shift = {hist_q[PAT_LEN-3:0], bus.x};
  end

  // rst gates y so a pattern completed in the reset cycle is not reported.
  assign y = bus.en & ~rst & (fill_q == FILL_MAX) & ({hist_q, bus.x} == PATTERN);

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = y;
    if (bus.en) begin
      hist_d = hist_shift;
      if (y && !bus.overlap) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (y && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = '0;
`endif

  assign bus.y   = y;
  assign bus.y_q = match_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: default 3'b111 detector, a 4'b1011 detector and a 2-bit-counter instance.
module tb_seq_detect_param;

  localparam int W = 1;

  typedef struct {
    logic rst;
    logic en;
    logic x;
    logic ov;
    logic y;
  } vec_t;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt [3];
  int   cnt_max [3];
  logic [W-1:0] exp_q[$];
  vec_t tbl[$];

  seq_detect_param_if #(.CNT_W(8)) if_a ();
  seq_detect_param_if #(.CNT_W(8)) if_b ();
  seq_detect_param_if #(.CNT_W(2)) if_c ();

  seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b111), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .bus(if_a)
  );
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .bus(if_b)
  );
  seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b111), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst_c), .bus(if_c)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic e, input logic xx, input logic ov);
    case (d)
      0: begin rst_a = r; if_a.en = e; if_a.x = xx; if_a.overlap = ov; end
      1: begin rst_b = r; if_b.en = e; if_b.x = xx; if_b.overlap = ov; end
      default: begin rst_c = r; if_c.en = e; if_c.x = xx; if_c.overlap = ov; end
    endcase
  endtask

  task automatic sample(input int d, output int yv, output int yqv, output int cv);
    case (d)
      0: begin yv = int'(if_a.y); yqv = int'(if_a.y_q); cv = int'(if_a.match_cnt); end
      1: begin yv = int'(if_b.y); yqv = int'(if_b.y_q); cv = int'(if_b.match_cnt); end
      default: begin yv = int'(if_c.y); yqv = int'(if_c.y_q); cv = int'(if_c.match_cnt); end
    endcase
  endtask

  // One clock: drive at negedge, check y now, y_q and match_cnt from the previous edge.
  task automatic step(input int d, input string tag, input logic r, input logic e,
                      input logic xx, input logic ov, input logic ey);
    int yv, yqv, cv, ec;
    logic [W-1:0] eq;
    @(negedge clk);
    drive(d, r, e, xx, ov);
    #1;
    sample(d, yv, yqv, cv);
    if (exp_q.size() > 0) begin
      eq = exp_q.pop_front();
      check($sformatf("%s y_q", tag), yqv, int'(eq));
    end
    check($sformatf("%s y", tag), yv, int'(ey));
`ifdef SEQ_DETECT_MATCH_CNT_EN
    ec = exp_cnt[d];
`else
    ec = 0;
`endif
    check($sformatf("%s match_cnt", tag), cv, ec);
    exp_q.push_back(ey);
    if (r) exp_cnt[d] = 0;
    else if (ey && exp_cnt[d] < cnt_max[d]) exp_cnt[d] = exp_cnt[d] + 1;
  endtask

  function automatic void add(input logic r, input logic e, input logic xx, input logic ov,
                              input logic ey);
    vec_t v;
    v.rst = r; v.en = e; v.x = xx; v.ov = ov; v.y = ey;
    tbl.push_back(v);
  endfunction

  initial begin
    int yv, yqv, cv;
    logic [6:0] bits;

    // overlap, five ones then three zeros
    add(1,1,0,1,0); add(1,1,0,1,0);
    add(0,1,1,1,0); add(0,1,1,1,0); add(0,1,1,1,1); add(0,1,1,1,1); add(0,1,1,1,1);
    add(0,1,0,1,0); add(0,1,0,1,0); add(0,1,0,1,0);
    // non-overlap, same stream
    add(1,1,0,0,0); add(1,1,0,0,0);
    add(0,1,1,0,0); add(0,1,1,0,0); add(0,1,1,0,1); add(0,1,1,0,0); add(0,1,1,0,0);
    add(0,1,0,0,0); add(0,1,0,0,0); add(0,1,0,0,0);
    // non-overlap, six ones: second match on bit 6
    add(1,1,0,0,0);
    add(0,1,1,0,0); add(0,1,1,0,0); add(0,1,1,0,1); add(0,1,1,0,0); add(0,1,1,0,0); add(0,1,1,0,1);
    // idle cycles inside a pattern
    add(1,1,0,1,0);
    add(0,1,1,1,0); add(0,1,1,1,0);
    add(0,0,1,1,0); add(0,0,1,1,0); add(0,0,1,1,0);
    add(0,1,1,1,1); add(0,1,1,1,1);
    // reset mid pattern
    add(1,1,0,1,0);
    add(0,1,1,1,0); add(0,1,1,1,0); add(1,1,1,1,0);
    add(0,1,1,1,0); add(0,1,1,1,0); add(0,1,1,1,1);
    // overlap switched off after a match; fill only clears on the next match
    add(1,1,0,1,0);
    add(0,1,1,1,0); add(0,1,1,1,0); add(0,1,1,1,1);
    add(0,1,1,0,1); add(0,1,1,0,0); add(0,1,1,0,0); add(0,1,1,0,1);
    add(0,1,0,1,0); add(0,0,0,1,0);

    cnt_max[0] = 255; cnt_max[1] = 255; cnt_max[2] = 3;

    // reset
    for (int d = 0; d < 3; d++) drive(d, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    for (int d = 0; d < 3; d++) begin
      sample(d, yv, yqv, cv);
      check($sformatf("reset dut%0d y", d), yv, 0);
      check($sformatf("reset dut%0d y_q", d), yqv, 0);
      check($sformatf("reset dut%0d match_cnt", d), cv, 0);
      exp_cnt[d] = 0;
    end

    // table vectors on the default detector
    exp_q.delete();
    for (int i = 0; i < tbl.size(); i++) begin
      step(0, $sformatf("tbl[%0d]", i), tbl[i].rst, tbl[i].en, tbl[i].x, tbl[i].ov, tbl[i].y);
    end
    step(0, "tbl tail", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 4'b1011 detector, overlap then non-overlap
    bits = 7'b1011011;
    exp_q.delete();
    step(1, "b1011 ov rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1, $sformatf("b1011 ov bit%0d", i + 1), 1'b0, 1'b1, bits[6-i], 1'b1, (i == 3) || (i == 6));
    end
    step(1, "b1011 nov rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1, $sformatf("b1011 nov bit%0d", i + 1), 1'b0, 1'b1, bits[6-i], 1'b0, i == 3);
    end
    step(1, "b1011 tail", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2-bit counter saturation under continuous overlapping matches
    exp_q.delete();
    step(2, "sat rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(2, $sformatf("sat bit%0d", i + 1), 1'b0, 1'b1, 1'b1, 1'b1, i >= 2);
    end
    step(2, "sat tail", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(2, "sat hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
